// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner with double-buffered display data and blink
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_FRAMES = 64,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [NUM_DIGITS-1:0]   blink,
   input  logic [NUM_DIGITS-1:0]   alt,
   input  logic                    load,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig,
   output logic                    frame_tick,
   output logic                    pending
);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] BL_MAX  = BW'(BLINK_FRAMES - 1);
   localparam logic [7:0] SEG_OFF = {8{ACTIVE_LOW != 0}};
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{ACTIVE_LOW != 0}};

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] nib;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blank;
      logic [NUM_DIGITS-1:0]   blink;
      logic [NUM_DIGITS-1:0]   alt;
   } disp_t;

   // everything dark until the first transfer
   localparam disp_t DISP_RST = disp_t'({{(5*NUM_DIGITS){1'b0}}, {NUM_DIGITS{1'b1}}, {(2*NUM_DIGITS){1'b0}}});

   logic [PW-1:0]         pre_q, pre_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [BW-1:0]         bl_cnt_q, bl_cnt_d;
   logic                  phase_q, phase_d;
   logic                  pending_q, pending_d;
   logic                  frame_tick_q, frame_tick_d;
   disp_t                 sh_q, sh_d, act_q, act_d;
   logic [7:0]            seg_q, seg_d, seg_l;
   logic [NUM_DIGITS-1:0] dig_q, dig_d, onehot;
   logic                  pre_wrap, boundary, dark, lit;

   // active-low glyph for bits g..a; alt selects 't' in place of 'A'
   function automatic logic [6:0] glyph(input logic [3:0] n, input logic a);
      case (n)
         4'h0:    glyph = 7'b1000000;
         4'h1:    glyph = 7'b1111001;
         4'h2:    glyph = 7'b0100100;
         4'h3:    glyph = 7'b0110000;
         4'h4:    glyph = 7'b0011001;
         4'h5:    glyph = 7'b0010010;
         4'h6:    glyph = 7'b0000010;
         4'h7:    glyph = 7'b1111000;
         4'h8:    glyph = 7'b0000000;
         4'h9:    glyph = 7'b0010000;
         4'hA:    glyph = a ? 7'b0000111 : 7'b0001000;
         4'hB:    glyph = 7'b0000011;
         4'hC:    glyph = 7'b1000110;
         4'hD:    glyph = 7'b0100001;
         4'hE:    glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   // next-state scan, buffering and blink; outputs are derived from the next state so the registered
   // seg/dig line up with the slot the counters are entering
   always_comb begin
      pre_wrap     = pre_q == PRE_MAX;
      boundary     = pre_wrap && idx_q == IDX_MAX;
      pre_d        = pre_wrap ? '0 : pre_q + 1'b1;
      idx_d        = !pre_wrap ? idx_q : boundary ? '0 : idx_q + 1'b1;
      bl_cnt_d     = !boundary ? bl_cnt_q : bl_cnt_q == BL_MAX ? '0 : bl_cnt_q + 1'b1;
      phase_d      = phase_q ^ (boundary && bl_cnt_q == BL_MAX);
      pending_d    = load || (pending_q && !boundary);
      sh_d         = load ? disp_t'({digits, dp, blank, blink, alt}) : sh_q;
      act_d        = boundary && pending_q ? sh_q : act_q;
      dark         = act_d.blank[idx_d] || (act_d.blink[idx_d] && phase_d);
      lit          = pre_d != '0 && !dark;
      onehot       = NUM_DIGITS'(1) << idx_d;
      seg_l        = {~act_d.dp[idx_d], glyph(act_d.nib[{idx_d, 2'b00} +: 4], act_d.alt[idx_d])};
      seg_d        = !lit ? SEG_OFF : ACTIVE_LOW != 0 ? seg_l : ~seg_l;
      dig_d        = !lit ? DIG_OFF : ACTIVE_LOW != 0 ? ~onehot : onehot;
      frame_tick_d = boundary;
   end

   // state and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q        <= '0;
         idx_q        <= '0;
         bl_cnt_q     <= '0;
         phase_q      <= 1'b0;
         pending_q    <= 1'b0;
         frame_tick_q <= 1'b0;
         sh_q         <= DISP_RST;
         act_q        <= DISP_RST;
         seg_q        <= SEG_OFF;
         dig_q        <= DIG_OFF;
      end else begin
         pre_q        <= pre_d;
         idx_q        <= idx_d;
         bl_cnt_q     <= bl_cnt_d;
         phase_q      <= phase_d;
         pending_q    <= pending_d;
         frame_tick_q <= frame_tick_d;
         sh_q         <= sh_d;
         act_q        <= act_d;
         seg_q        <= seg_d;
         dig_q        <= dig_d;
      end
   end

   assign seg        = seg_q;
   assign dig        = dig_q;
   assign frame_tick = frame_tick_q;
   assign pending    = pending_q;
endmodule
